// File: rtl/reg_file_rename.sv
// ----------------------------------------------------------------------------
// reg_file_rename
//
// Architectural register file with per-register rename tags. Holds REG_NUM
// committed data words plus, for every register, the ROB id of its newest
// in-flight writer (tag 0 = no pending writer). x0 is hard-wired to zero.
//
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN
//   defined   - a commit that clears a register's tag is forwarded to the
//               operand query in the same cycle (V = committed value, Q = 0).
//   undefined - queries see stored state only.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   rdy                       global ready; low freezes all state
//   rs1_from_dsp/rs2_from_dsp operand indices from the dispatcher
//   V1/Q1_to_dsp, V2/Q2_to_dsp operand value and pending tag (combinational)
//   ena_from_dsp, rd_from_dsp, rob_id_from_dsp   rename request
//   commit_flag_from_rob, rd_from_rob, Q_from_rob, V_from_rob   commit
//   rollback_flag_from_rob    clears every tag, keeps data
// ----------------------------------------------------------------------------
module reg_file_rename #(
    parameter int REG_NUM      = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int ROB_ID_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [4:0]              rs1_from_dsp,
    input  logic [4:0]              rs2_from_dsp,
    output logic [DATA_WIDTH-1:0]   V1_to_dsp,
    output logic [ROB_ID_WIDTH-1:0] Q1_to_dsp,
    output logic [DATA_WIDTH-1:0]   V2_to_dsp,
    output logic [ROB_ID_WIDTH-1:0] Q2_to_dsp,
    input  logic                    ena_from_dsp,
    input  logic [4:0]              rd_from_dsp,
    input  logic [ROB_ID_WIDTH-1:0] rob_id_from_dsp,
    input  logic                    commit_flag_from_rob,
    input  logic [4:0]              rd_from_rob,
    input  logic [ROB_ID_WIDTH-1:0] Q_from_rob,
    input  logic [DATA_WIDTH-1:0]   V_from_rob,
    input  logic                    rollback_flag_from_rob
);

    localparam logic [DATA_WIDTH-1:0]   DATA_ZERO = {DATA_WIDTH{1'b0}};
    localparam logic [ROB_ID_WIDTH-1:0] TAG_ZERO  = {ROB_ID_WIDTH{1'b0}};

    logic [DATA_WIDTH-1:0]   data_q [REG_NUM];
    logic [DATA_WIDTH-1:0]   data_d [REG_NUM];
    logic [ROB_ID_WIDTH-1:0] tag_q  [REG_NUM];
    logic [ROB_ID_WIDTH-1:0] tag_d  [REG_NUM];

    logic byp1_s;
    logic byp2_s;

    // Operand lookup: x0 reads as zero; a bypass hit forwards the committing value.
    function automatic logic [DATA_WIDTH+ROB_ID_WIDTH-1:0] query_f(
        input logic [4:0]              rs,
        input logic [DATA_WIDTH-1:0]   data_s,
        input logic [ROB_ID_WIDTH-1:0] tag_s,
        input logic                    byp_s,
        input logic [DATA_WIDTH-1:0]   byp_data_s
    );
        logic [DATA_WIDTH+ROB_ID_WIDTH-1:0] res_s;
        if (rs == 5'd0) begin
            res_s = {DATA_ZERO, TAG_ZERO};
        end else if (byp_s) begin
            res_s = {byp_data_s, TAG_ZERO};
        end else begin
            res_s = {data_s, tag_s};
        end
        return res_s;
    endfunction

    // Bypass qualification: only the commit that actually retires the newest
    // writer (tag match) may be forwarded; an older commit leaves the tag live.
`ifdef REGFILE_COMMIT_BYPASS_EN
    always_comb begin
        byp1_s = commit_flag_from_rob && (rd_from_rob == rs1_from_dsp)
                 && (tag_q[rs1_from_dsp] == Q_from_rob);
        byp2_s = commit_flag_from_rob && (rd_from_rob == rs2_from_dsp)
                 && (tag_q[rs2_from_dsp] == Q_from_rob);
    end
`else
    always_comb begin
        byp1_s = 1'b0;
        byp2_s = 1'b0;
    end
`endif

    // Combinational operand query for both dispatcher ports.
    always_comb begin
        {V1_to_dsp, Q1_to_dsp} = query_f(rs1_from_dsp, data_q[rs1_from_dsp],
                                         tag_q[rs1_from_dsp], byp1_s, V_from_rob);
        {V2_to_dsp, Q2_to_dsp} = query_f(rs2_from_dsp, data_q[rs2_from_dsp],
                                         tag_q[rs2_from_dsp], byp2_s, V_from_rob);
    end

    // Next-state: commit data always lands; tag priority is
    // rollback clear > rename > matching-commit clear.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            data_d[i] = data_q[i];
            tag_d[i]  = tag_q[i];
            if (i == 0) begin
                data_d[i] = DATA_ZERO;
                tag_d[i]  = TAG_ZERO;
            end else begin
                if (commit_flag_from_rob && (rd_from_rob == 5'(i))) begin
                    data_d[i] = V_from_rob;
                end else begin
                    data_d[i] = data_q[i];
                end

                if (rollback_flag_from_rob) begin
                    tag_d[i] = TAG_ZERO;
                end else if (ena_from_dsp && (rd_from_dsp == 5'(i))) begin
                    tag_d[i] = rob_id_from_dsp;
                end else if (commit_flag_from_rob && (rd_from_rob == 5'(i))
                             && (tag_q[i] == Q_from_rob)) begin
                    tag_d[i] = TAG_ZERO;
                end else begin
                    tag_d[i] = tag_q[i];
                end
            end
        end
    end

    // State registers: reset clears everything, rdy low holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                data_q[i] <= DATA_ZERO;
                tag_q[i]  <= TAG_ZERO;
            end
        end else if (rdy) begin
            data_q <= data_d;
            tag_q  <= tag_d;
        end else begin
            data_q <= data_q;
            tag_q  <= tag_q;
        end
    end

endmodule

// File: tb/tb_reg_file_rename.sv
module tb_reg_file_rename;

`ifdef REGFILE_COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        ena;
        logic [4:0]  rd_d;
        logic [4:0]  id;
        logic        cm;
        logic [4:0]  rd_r;
        logic [4:0]  q_r;
        logic [31:0] v_r;
        logic        rb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] ev1;
        logic [4:0]  eq1;
        logic [31:0] ev2;
        logic [4:0]  eq2;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [4:0]  rs1_from_dsp;
    logic [4:0]  rs2_from_dsp;
    logic [31:0] V1_to_dsp;
    logic [4:0]  Q1_to_dsp;
    logic [31:0] V2_to_dsp;
    logic [4:0]  Q2_to_dsp;
    logic        ena_from_dsp;
    logic [4:0]  rd_from_dsp;
    logic [4:0]  rob_id_from_dsp;
    logic        commit_flag_from_rob;
    logic [4:0]  rd_from_rob;
    logic [4:0]  Q_from_rob;
    logic [31:0] V_from_rob;
    logic        rollback_flag_from_rob;

    int total;
    int bad;

    // Reference state: committed value and newest pending writer per register.
    logic [31:0] m_data [32];
    logic [4:0]  m_tag  [32];

    reg_file_rename dut (
        .clk                    (clk),
        .rst                    (rst),
        .rdy                    (rdy),
        .rs1_from_dsp           (rs1_from_dsp),
        .rs2_from_dsp           (rs2_from_dsp),
        .V1_to_dsp              (V1_to_dsp),
        .Q1_to_dsp              (Q1_to_dsp),
        .V2_to_dsp              (V2_to_dsp),
        .Q2_to_dsp              (Q2_to_dsp),
        .ena_from_dsp           (ena_from_dsp),
        .rd_from_dsp            (rd_from_dsp),
        .rob_id_from_dsp        (rob_id_from_dsp),
        .commit_flag_from_rob   (commit_flag_from_rob),
        .rd_from_rob            (rd_from_rob),
        .Q_from_rob             (Q_from_rob),
        .V_from_rob             (V_from_rob),
        .rollback_flag_from_rob (rollback_flag_from_rob)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        input logic r, input logic rd_ok, input logic e, input logic [4:0] rdd,
        input logic [4:0] idv, input logic c, input logic [4:0] rdr,
        input logic [4:0] qr, input logic [31:0] vr, input logic b,
        input logic [4:0] a1, input logic [4:0] a2,
        input logic [31:0] v1, input logic [4:0] q1,
        input logic [31:0] v2, input logic [4:0] q2);
        vec_t v;
        v.rst = r;   v.rdy = rd_ok; v.ena = e;  v.rd_d = rdd; v.id = idv;
        v.cm = c;    v.rd_r = rdr;  v.q_r = qr; v.v_r = vr;   v.rb = b;
        v.rs1 = a1;  v.rs2 = a2;
        v.ev1 = v1;  v.eq1 = q1;    v.ev2 = v2; v.eq2 = q2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected query result straight from the reference state.
    task automatic model_query(input logic [4:0] rs, input vec_t v,
                               output logic [31:0] ev, output logic [4:0] eq);
        if (rs == 5'd0) begin
            ev = 32'd0; eq = 5'd0;
        end else if (BYP && v.cm && v.rd_r == rs && m_tag[rs] == v.q_r) begin
            ev = v.v_r; eq = 5'd0;
        end else begin
            ev = m_data[rs]; eq = m_tag[rs];
        end
    endtask

    // Reference update for one clock edge.
    task automatic model_step(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin
                m_data[i] = 32'd0; m_tag[i] = 5'd0;
            end
        end else if (v.rdy) begin
            logic [4:0] old_tag;
            old_tag = m_tag[v.rd_r];
            if (v.cm && v.rd_r != 5'd0) m_data[v.rd_r] = v.v_r;
            if (v.rb) begin
                for (int i = 0; i < 32; i++) m_tag[i] = 5'd0;
            end else begin
                if (v.cm && v.rd_r != 5'd0 && old_tag == v.q_r) m_tag[v.rd_r] = 5'd0;
                if (v.ena && v.rd_d != 5'd0) m_tag[v.rd_d] = v.id;
            end
        end
    endtask

    // One cycle: drive at negedge, compare before the edge, then clock.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        rst = v.rst; rdy = v.rdy;
        ena_from_dsp = v.ena; rd_from_dsp = v.rd_d; rob_id_from_dsp = v.id;
        commit_flag_from_rob = v.cm; rd_from_rob = v.rd_r;
        Q_from_rob = v.q_r; V_from_rob = v.v_r;
        rollback_flag_from_rob = v.rb;
        rs1_from_dsp = v.rs1; rs2_from_dsp = v.rs2;
        #1;
        chk({tag, "_V1"}, V1_to_dsp, v.ev1);
        chk({tag, "_Q1"}, {27'd0, Q1_to_dsp}, {27'd0, v.eq1});
        chk({tag, "_V2"}, V2_to_dsp, v.ev2);
        chk({tag, "_Q2"}, {27'd0, Q2_to_dsp}, {27'd0, v.eq2});
        @(posedge clk);
        model_step(v);
    endtask

    vec_t vecs [18];

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b1; rdy = 1'b1;
        ena_from_dsp = 1'b0; rd_from_dsp = 5'd0; rob_id_from_dsp = 5'd0;
        commit_flag_from_rob = 1'b0; rd_from_rob = 5'd0; Q_from_rob = 5'd0;
        V_from_rob = 32'd0; rollback_flag_from_rob = 1'b0;
        rs1_from_dsp = 5'd0; rs2_from_dsp = 5'd0;
        for (int i = 0; i < 32; i++) begin
            m_data[i] = 32'd0; m_tag[i] = 5'd0;
        end
        repeat (2) @(posedge clk);

        //             rst  rdy  ena  rd_d  id    cm   rd_r  q_r   v_r           rb   rs1   rs2   ev1                                eq1                 ev2                     eq2
        vecs[0]  = mk(1'b0,1'b1,1'b1,5'd5, 5'd3, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd5, 5'd0, 32'h0,                             5'd0,               32'h0,                  5'd0);
        vecs[1]  = mk(1'b0,1'b1,1'b1,5'd7, 5'd2, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd5, 5'd7, 32'h0,                             5'd3,               32'h0,                  5'd0);
        vecs[2]  = mk(1'b0,1'b1,1'b1,5'd7, 5'd4, 1'b1,5'd5, 5'd3, 32'hDEADBEEF, 1'b0,5'd5, 5'd7, BYP ? 32'hDEADBEEF : 32'h0,       BYP ? 5'd0 : 5'd3,  32'h0,                  5'd2);
        vecs[3]  = mk(1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b1,5'd7, 5'd2, 32'h11,       1'b0,5'd5, 5'd7, 32'hDEADBEEF,                      5'd0,               32'h0,                  5'd4);
        vecs[4]  = mk(1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b1,5'd7, 5'd4, 32'h22,       1'b0,5'd7, 5'd5, BYP ? 32'h22 : 32'h11,             BYP ? 5'd0 : 5'd4,  32'hDEADBEEF,           5'd0);
        vecs[5]  = mk(1'b0,1'b1,1'b1,5'd9, 5'd6, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd7, 5'd9, 32'h22,                            5'd0,               32'h0,                  5'd0);
        vecs[6]  = mk(1'b0,1'b1,1'b1,5'd9, 5'd8, 1'b1,5'd9, 5'd6, 32'h55,       1'b0,5'd9, 5'd0, BYP ? 32'h55 : 32'h0,              BYP ? 5'd0 : 5'd6,  32'h0,                  5'd0);
        vecs[7]  = mk(1'b0,1'b1,1'b1,5'd1, 5'd1, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd9, 5'd1, 32'h55,                            5'd8,               32'h0,                  5'd0);
        vecs[8]  = mk(1'b0,1'b1,1'b1,5'd2, 5'd2, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd1, 5'd0, 32'h0,                             5'd1,               32'h0,                  5'd0);
        vecs[9]  = mk(1'b0,1'b1,1'b1,5'd3, 5'd3, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd2, 5'd9, 32'h0,                             5'd2,               32'h55,                 5'd8);
        vecs[10] = mk(1'b0,1'b1,1'b1,5'd4, 5'd5, 1'b1,5'd1, 5'd1, 32'h99,       1'b1,5'd3, 5'd1, 32'h0,                             5'd3,               BYP ? 32'h99 : 32'h0,   BYP ? 5'd0 : 5'd1);
        vecs[11] = mk(1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd1, 5'd4, 32'h99,                            5'd0,               32'h0,                  5'd0);
        vecs[12] = mk(1'b0,1'b1,1'b1,5'd0, 5'd2, 1'b1,5'd0, 5'd0, 32'h7,        1'b0,5'd9, 5'd3, 32'h55,                            5'd0,               32'h0,                  5'd0);
        vecs[13] = mk(1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd0, 5'd7, 32'h0,                             5'd0,               32'h22,                 5'd0);
        vecs[14] = mk(1'b0,1'b0,1'b1,5'd3, 5'd1, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd0, 5'd3, 32'h0,                             5'd0,               32'h0,                  5'd0);
        vecs[15] = mk(1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd3, 5'd5, 32'h0,                             5'd0,               32'hDEADBEEF,           5'd0);
        vecs[16] = mk(1'b1,1'b1,1'b1,5'd6, 5'd7, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd9, 5'd0, 32'h55,                            5'd0,               32'h0,                  5'd0);
        vecs[17] = mk(1'b0,1'b1,1'b0,5'd0, 5'd0, 1'b0,5'd0, 5'd0, 32'h0,        1'b0,5'd9, 5'd6, 32'h0,                             5'd0,               32'h0,                  5'd0);

        for (int i = 0; i < 18; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Randomised traffic checked against the reference state.
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v.rst  = ($urandom_range(0, 99) == 0);
            v.rdy  = ($urandom_range(0, 7) != 0);
            v.ena  = $urandom_range(0, 1) == 1;
            v.rd_d = 5'($urandom_range(0, 31));
            v.id   = 5'($urandom_range(1, 31));
            v.cm   = $urandom_range(0, 1) == 1;
            v.rd_r = 5'($urandom_range(0, 31));
            v.q_r  = ($urandom_range(0, 3) != 0) ? m_tag[v.rd_r] : 5'($urandom_range(1, 31));
            v.v_r  = $urandom;
            v.rb   = ($urandom_range(0, 24) == 0);
            v.rs1  = ($urandom_range(0, 1) == 1) ? v.rd_r : 5'($urandom_range(0, 31));
            v.rs2  = 5'($urandom_range(0, 31));
            model_query(v.rs1, v, v.ev1, v.eq1);
            model_query(v.rs2, v, v.ev2, v.eq2);
            apply(v, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
